// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, sizes and the round-robin pick function for mux_rr_arbiter
package mux_arb_pkg;
  localparam int DW = 4;
  localparam int N_REQ = 4;
  typedef logic [1:0] sel_t;
  typedef logic [DW-1:0] data_t;
  typedef enum logic {IDLE, FULL} state_t;
  function automatic sel_t rr_pick(input logic [N_REQ-1:0] elig, input sel_t ptr);
    sel_t w;
    sel_t idx;
    w = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (elig[idx]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux_rr_arbiter_mux: 4:1 data mux; a..d data in, sel picks one onto y
module mux_rr_arbiter_mux #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [1:0]    sel,
  output logic [DW-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter over 4 valid/ready requesters (a..d) feeding a one-entry out_valid/out_ready/out_data/out_sel register
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW = mux_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req_en,
  input  logic [3:0]    req_valid,
  output logic [3:0]    req_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_sel
);
  state_t state, state_n;
  sel_t rr_ptr, win;
  logic [3:0] elig;
  logic acc;
  logic [DW-1:0] mux_y;
  mux_rr_arbiter_mux #(.DW(DW)) u_mux (
    .a(a), .b(b), .c(c), .d(d), .sel(win), .y(mux_y)
  );
  always_comb begin
    elig = req_valid & req_en;
    win = rr_pick(elig, rr_ptr);
    acc = !rst && (state == IDLE || out_ready) && |elig;
    req_ready = acc ? 4'b0001 << win : 4'b0000;
    state_n = acc ? FULL : (out_ready ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      out_data <= '0;
      out_sel <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        out_data <= mux_y;
        out_sel <= win;
        rr_ptr <= win + sel_t'(1);
      end
    end
  end
  assign out_valid = state == FULL;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: table-driven directed bench for mux_rr_arbiter
module tb_mux_rr_arbiter;
  logic clk = 0, rst = 1, out_ready = 0, out_valid;
  logic [3:0] req_en = 0, req_valid = 0, req_ready, a = 0, b = 0, c = 0, d = 0, out_data;
  logic [1:0] out_sel;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst;
    logic [3:0] en, valid;
    logic ordy;
    logic [3:0] a, b, c, d;
    logic [3:0] exp_ready;
    logic exp_ov;
    logic [3:0] exp_data;
    logic [1:0] exp_sel;
  } vec_t;
  vec_t tv[22];
  mux_rr_arbiter dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic r, input logic [3:0] en, input logic [3:0] v, input logic o,
                              input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic, input logic [3:0] id,
                              input logic [3:0] er, input logic eov, input logic [3:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r; t.en = en; t.valid = v; t.ordy = o;
    t.a = ia; t.b = ib; t.c = ic; t.d = id;
    t.exp_ready = er; t.exp_ov = eov; t.exp_data = ed; t.exp_sel = es;
    return t;
  endfunction
  initial begin
    logic [1:0] es;
    tv[0]  = mk(1, 4'hF, 4'hF,    1, 5, 2, 3, 4, 4'b0000, 0, 4'h0, 0);
    tv[1]  = mk(0, 4'hF, 4'b0001, 1, 5, 2, 3, 4, 4'b0001, 1, 4'h5, 0);
    tv[2]  = mk(0, 4'hF, 4'b0000, 1, 5, 2, 3, 4, 4'b0000, 0, 4'h5, 0);
    tv[3]  = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0010, 1, 4'h2, 1);
    tv[4]  = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0100, 1, 4'h3, 2);
    tv[5]  = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b1000, 1, 4'h4, 3);
    tv[6]  = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0001, 1, 4'h1, 0);
    tv[7]  = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0010, 1, 4'h2, 1);
    tv[8]  = mk(0, 4'hF, 4'hF,    0, 1, 2, 3, 4, 4'b0000, 1, 4'h2, 1);
    tv[9]  = mk(0, 4'hF, 4'hF,    0, 1, 2, 3, 4, 4'b0000, 1, 4'h2, 1);
    tv[10] = mk(0, 4'hF, 4'hF,    0, 1, 2, 3, 4, 4'b0000, 1, 4'h2, 1);
    tv[11] = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0100, 1, 4'h3, 2);
    tv[12] = mk(0, 4'b1010, 4'hF, 1, 1, 2, 3, 4, 4'b1000, 1, 4'h4, 3);
    tv[13] = mk(0, 4'b1010, 4'hF, 1, 1, 2, 3, 4, 4'b0010, 1, 4'h2, 1);
    tv[14] = mk(0, 4'b1010, 4'hF, 1, 1, 2, 3, 4, 4'b1000, 1, 4'h4, 3);
    tv[15] = mk(0, 4'b1010, 4'hF, 1, 1, 2, 3, 4, 4'b0010, 1, 4'h2, 1);
    tv[16] = mk(0, 4'hF, 4'b0010, 1, 1, 9, 3, 4, 4'b0010, 1, 4'h9, 1);
    tv[17] = mk(0, 4'hF, 4'hF,    0, 1, 9, 3, 4, 4'b0000, 1, 4'h9, 1);
    tv[18] = mk(1, 4'hF, 4'hF,    0, 1, 9, 3, 4, 4'b0000, 0, 4'h0, 0);
    tv[19] = mk(0, 4'hF, 4'hF,    1, 1, 2, 3, 4, 4'b0001, 1, 4'h1, 0);
    tv[20] = mk(0, 4'h0, 4'hF,    0, 1, 2, 3, 4, 4'b0000, 1, 4'h1, 0);
    tv[21] = mk(0, 4'h0, 4'hF,    1, 1, 2, 3, 4, 4'b0000, 0, 4'h1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) begin
      rst = tv[i].rst; req_en = tv[i].en; req_valid = tv[i].valid; out_ready = tv[i].ordy;
      a = tv[i].a; b = tv[i].b; c = tv[i].c; d = tv[i].d;
      #1;
      chk("req_ready", i, int'(req_ready), int'(tv[i].exp_ready));
      @(posedge clk); #1;
      chk("out_valid", i, int'(out_valid), int'(tv[i].exp_ov));
      chk("out_data", i, int'(out_data), int'(tv[i].exp_data));
      chk("out_sel", i, int'(out_sel), int'(tv[i].exp_sel));
    end
    // rr_ptr is 1 here: sustained all-valid traffic must stream with no bubbles
    rst = 0; req_en = 4'hF; req_valid = 4'hF; out_ready = 1; a = 1; b = 2; c = 3; d = 4;
    es = 2'd1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stream_ready", 100 + i, int'(req_ready), int'(4'b0001 << es));
      @(posedge clk); #1;
      chk("stream_valid", 100 + i, int'(out_valid), 1);
      chk("stream_sel", 100 + i, int'(out_sel), int'(es));
      chk("stream_data", 100 + i, int'(out_data), int'(es) + 1);
      es = es + 2'd1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
